// File: rtl/uart_rx_conditioner.sv
// uart_rx_conditioner
//   Conditions the raw UART RX pad before it reaches the SoC uart_rx input.
//   The pin is synchronised into clk and short glitches are rejected and counted.
//   A sustained low level on the filtered line is reported as a line break.
//
// Optional feature, compiled in by defining UART_RX_CONDITIONER_BREAK_RESET_EN:
//   each new break issues one RST_PULSE_CYCLES-long low pulse on rst_req_n.
//   When the macro is not defined, rst_req_n is tied high and no timer is built.
//
// Ports:
//   clk           system clock (only clock)
//   rst           async active-high reset, power-on only
//   rx_pin        raw asynchronous RX pad, idle high
//   rx_out        filtered RX to the SoC
//   break_active  high while a line break is in progress
//   glitch_count  saturating count of rejected glitches
//   rst_req_n     active-low reset request (constant 1 without the feature)
module uart_rx_conditioner #(
  parameter int SYNC_STAGES      = 2,
  parameter int FILTER_CYCLES    = 4,
  parameter int BREAK_CYCLES     = 120000,
  parameter int RST_PULSE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic       rx_out,
  output logic       break_active,
  output logic [7:0] glitch_count,
  output logic       rst_req_n
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int BW = $clog2(BREAK_CYCLES + 1);

  // Elaboration-time parameter range checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
    $error("FILTER_CYCLES out of range 1..255");
  end
  if (BREAK_CYCLES < 2) begin : g_bad_break
    $error("BREAK_CYCLES must be at least 2");
  end
  if (RST_PULSE_CYCLES < 1 || RST_PULSE_CYCLES > 255) begin : g_bad_pulse
    $error("RST_PULSE_CYCLES out of range 1..255");
  end

  // Synchroniser; resets to the idle (high) level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Glitch filter. A new level must be seen FILTER_CYCLES cycles in a row;
  // the output flips on the edge where the count would reach FILTER_CYCLES.
  // Reverting early with a partial count is a rejected glitch.
  logic [FW-1:0] fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt         <= '0;
      rx_out       <= 1'b1;
      glitch_count <= '0;
    end else if (rx_s != rx_out) begin
      if (fcnt == FW'(FILTER_CYCLES - 1)) begin
        rx_out <= rx_s;
        fcnt   <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end else if (fcnt != '0) begin
      fcnt <= '0;
      if (glitch_count != 8'hff) glitch_count <= glitch_count + 8'd1;
    end
  end

  // Break detector, running on the registered filtered line.
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        if (!rx_out) begin
          state_d = S_LOW;
          bcnt_d  = BW'(1);
        end
      end
      S_LOW: begin
        // A rise on the threshold cycle wins over the break.
        if (rx_out) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BW'(BREAK_CYCLES - 1)) state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_out) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else if (bcnt_q != BW'(BREAK_CYCLES)) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  assign break_active = (state_q == S_BREAK);

`ifdef UART_RX_CONDITIONER_BREAK_RESET_EN
  // The LOW->BREAK transition is registered once, so the pulse starts one
  // cycle after break_active rises. A running pulse ignores new triggers
  // and always runs to completion.
  logic       trig_q;
  logic [7:0] ptmr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q    <= 1'b0;
      ptmr      <= '0;
      rst_req_n <= 1'b1;
    end else begin
      trig_q <= (state_q == S_LOW) && (state_d == S_BREAK);
      if (!rst_req_n) begin
        if (ptmr == '0) rst_req_n <= 1'b1;
        else            ptmr      <= ptmr - 8'd1;
      end else if (trig_q) begin
        rst_req_n <= 1'b0;
        ptmr      <= 8'(RST_PULSE_CYCLES - 1);
      end
    end
  end
`else
  assign rst_req_n = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_conditioner.sv
// Bench for uart_rx_conditioner (SYNC 2, FILTER 4, BREAK 100, PULSE 16).
// Output edges on rx_out / break_active / rst_req_n are matched in order
// against a queue of expected (kind, value, cycle) events.
module tb_uart_rx_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic       rx_out;
  logic       break_active;
  logic [7:0] glitch_count;
  logic       rst_req_n;

  uart_rx_conditioner #(
    .SYNC_STAGES     (2),
    .FILTER_CYCLES   (4),
    .BREAK_CYCLES    (100),
    .RST_PULSE_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_pin      (rx_pin),
    .rx_out      (rx_out),
    .break_active(break_active),
    .glitch_count(glitch_count),
    .rst_req_n   (rst_req_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // kind: 0 = rx_out, 1 = break_active, 2 = rst_req_n
  typedef struct {
    int kind;
    int val;
    int cyc;
  } evt_t;

  evt_t exp_q[$];

  logic mon_en = 1'b0;
  logic p_rx, p_brk, p_rst;

  task automatic push(input int kind, input int val, input int c);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic got_evt(input int kind, input int val);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL evt_unexpected: got kind=%0d val=%0d cyc=%0d expected none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      assert (e.kind == kind && e.val == val && e.cyc == cyc)
      else begin
        failures++;
        $error("FAIL evt: got kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
               kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_out !== p_rx) begin
        got_evt(0, int'(rx_out));
        p_rx = rx_out;
      end
      if (break_active !== p_brk) begin
        got_evt(1, int'(break_active));
        p_brk = break_active;
      end
      if (rst_req_n !== p_rst) begin
        got_evt(2, int'(rst_req_n));
        p_rst = rst_req_n;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Low pulse of len cycles on the pin, then enough idle for the filter to settle.
  task automatic pulse(input int len);
    rx_pin = 1'b0;
    wait_cyc(len);
    rx_pin = 1'b1;
    wait_cyc(6);
  endtask

  task automatic resync_monitor();
    p_rx   = rx_out;
    p_brk  = break_active;
    p_rst  = rst_req_n;
    mon_en = 1'b1;
  endtask

  initial begin
    int n;
    int exp_g;

    rst    = 1'b1;
    rx_pin = 1'b1;
    wait_cyc(3);
    chk("reset_rx_out", rx_out, 1);
    chk("reset_break", break_active, 0);
    chk("reset_glitch", glitch_count, 0);
    chk("reset_rst_req_n", rst_req_n, 1);
    rst = 1'b0;
    resync_monitor();
    wait_cyc(5);

    // Clean falling edge: rx_out follows after SYNC + FILTER cycles.
    n = cyc;
    rx_pin = 1'b0;
    push(0, 0, n + 6);
    wait_cyc(20);
    chk("edge_glitch", glitch_count, 0);
    chk("edge_q", exp_q.size(), 0);
    n = cyc;
    rx_pin = 1'b1;
    push(0, 1, n + 6);
    wait_cyc(15);
    chk("edge_rise_q", exp_q.size(), 0);

    // Glitches
    exp_g = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(1);
      exp_g++;
      chk("glitch_single", glitch_count, exp_g);
    end
    pulse(3);
    exp_g++;
    chk("glitch_3cyc", glitch_count, exp_g);
    chk("glitch_rx_out", rx_out, 1);
    for (int i = 0; i < 300; i++) begin
      pulse(1);
      if (exp_g < 255) exp_g++;
    end
    chk("glitch_sat", glitch_count, exp_g);
    chk("glitch_sat_255", glitch_count, 255);

    // 99 low cycles on rx_out: no break, rise wins on the threshold cycle.
    n = cyc;
    rx_pin = 1'b0;
    push(0, 0, n + 6);
    push(0, 1, n + 105);
    wait_cyc(99);
    rx_pin = 1'b1;
    wait_cyc(20);
    chk("b99_break", break_active, 0);
    chk("b99_q", exp_q.size(), 0);

    // 100 low cycles: one-cycle break.
    n = cyc;
    rx_pin = 1'b0;
    push(0, 0, n + 6);
    push(0, 1, n + 106);
    push(1, 1, n + 106);
    push(1, 0, n + 107);
`ifdef UART_RX_CONDITIONER_BREAK_RESET_EN
    push(2, 0, n + 107);
    push(2, 1, n + 123);
`endif
    wait_cyc(100);
    rx_pin = 1'b1;
    wait_cyc(40);
    chk("b100_q", exp_q.size(), 0);
    chk("b100_break", break_active, 0);

    // Break lasting 5 cycles: the reset pulse still runs its full length.
    n = cyc;
    rx_pin = 1'b0;
    push(0, 0, n + 6);
    push(1, 1, n + 106);
`ifdef UART_RX_CONDITIONER_BREAK_RESET_EN
    push(2, 0, n + 107);
`endif
    push(0, 1, n + 110);
    push(1, 0, n + 111);
`ifdef UART_RX_CONDITIONER_BREAK_RESET_EN
    push(2, 1, n + 123);
`endif
    wait_cyc(104);
    rx_pin = 1'b1;
    wait_cyc(40);
    chk("early_q", exp_q.size(), 0);
    chk("early_rst_req_n", rst_req_n, 1);

    // Async reset mid-break with the pin still low.
    n = cyc;
    rx_pin = 1'b0;
    push(0, 0, n + 6);
    push(1, 1, n + 106);
`ifdef UART_RX_CONDITIONER_BREAK_RESET_EN
    push(2, 0, n + 107);
`endif
    wait_cyc(110);
    chk("mid_pre_break", break_active, 1);
    chk("mid_pre_q", exp_q.size(), 0);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rx_out", rx_out, 1);
    chk("mid_break", break_active, 0);
    chk("mid_glitch", glitch_count, 0);
    chk("mid_rst_req_n", rst_req_n, 1);
    wait_cyc(3);
    rx_pin = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    resync_monitor();
    wait_cyc(3);

    // Operation resumes after reset.
    n = cyc;
    rx_pin = 1'b0;
    push(0, 0, n + 6);
    wait_cyc(10);
    n = cyc;
    rx_pin = 1'b1;
    push(0, 1, n + 6);
    wait_cyc(15);
    chk("post_q", exp_q.size(), 0);
    chk("post_glitch", glitch_count, 0);
    chk("post_rst_req_n", rst_req_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
